// File: rtl/noc_funnel_pkg.sv
// Shared types and tag decoding for the NOC request funnel.
// Tag values select how many payload beats follow the header beat.
package noc_funnel_pkg;

  localparam logic [31:0] TAG_SAY  = 32'd1;
  localparam logic [31:0] TAG_SAY2 = 32'd2;

  typedef struct packed {
    logic [15:0] length;
    logic [15:0] tag;
  } funnel_hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } funnel_state_t;

  // Unknown tags still carry the full three-word data field.
  function automatic logic [1:0] payload_beats(input logic [31:0] tag);
    return (tag == TAG_SAY) ? 2'd2 : 2'd3;
  endfunction

  function automatic logic tag_known(input logic [31:0] tag);
    return (tag == TAG_SAY) || (tag == TAG_SAY2);
  endfunction

endpackage

// File: rtl/noc_request_funnel.sv
// Serialises 128-bit echo requests into a header beat plus N payload beats
// on a 32-bit NOC link using enq__ENA/enq__RDY handshakes on both sides.
module noc_request_funnel
  import noc_funnel_pkg::*;
#(
  parameter int MSG_WIDTH  = 128,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  in_enq__ENA,
  input  logic [MSG_WIDTH-1:0]  in_enq_v,
  output logic                  in_enq__RDY,
  output logic                  out_enq__ENA,
  output logic [BEAT_WIDTH-1:0] out_enq_v,
  input  logic                  out_enq__RDY,
  output logic [15:0]           msg_count,
  output logic                  err_tag
);

  // Handshake: a transfer occurs on a rising CLK edge when ENA is high;
  // ENA is only ever raised while the receiving side's RDY is high.
  funnel_state_t               state;
  logic [1:0]                  idx;
  logic [1:0]                  len;
  logic [15:0]                 hold_tag;
  logic [2:0][BEAT_WIDTH-1:0]  hold_data;
  logic                        last;
  logic                        accept;
  funnel_hdr_t                 hdr;

  assign last         = (idx == (len - 2'd1));
  assign in_enq__RDY  = (state == ST_IDLE) ||
                        ((state == ST_PAY) && last && out_enq__RDY);
  assign accept       = in_enq__ENA && in_enq__RDY;
  assign out_enq__ENA = (state != ST_IDLE) && out_enq__RDY;

  always_comb begin
    hdr.length = {14'd0, len};
    hdr.tag    = hold_tag;
    out_enq_v  = '0;
    case (state)
      ST_HDR:  out_enq_v = hdr;
      ST_PAY:  out_enq_v = hold_data[idx];
      default: out_enq_v = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      idx       <= 2'd0;
      len       <= 2'd0;
      hold_tag  <= '0;
      hold_data <= '0;
      msg_count <= 16'd0;
      err_tag   <= 1'b0;
    end else begin
      // An accept in PAY only happens on the last beat, so it overrides the
      // normal PAY -> IDLE step and gives back-to-back messages.
      if (accept) begin
        hold_tag  <= in_enq_v[15:0];
        hold_data <= in_enq_v[MSG_WIDTH-1:BEAT_WIDTH];
        len       <= payload_beats(in_enq_v[31:0]);
        idx       <= 2'd0;
        state     <= ST_HDR;
        if (!tag_known(in_enq_v[31:0])) err_tag <= 1'b1;
      end else begin
        case (state)
          ST_HDR: if (out_enq__RDY) begin
            state <= ST_PAY;
            idx   <= 2'd0;
          end
          ST_PAY: if (out_enq__RDY) begin
            if (last) state <= ST_IDLE;
            else      idx   <= idx + 2'd1;
          end
          default: ;
        endcase
      end
      if (out_enq__ENA && (state == ST_PAY) && last)
        msg_count <= msg_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_noc_request_funnel.sv
// Directed bench for noc_request_funnel: per-scenario tasks with inline
// checks plus a beat scoreboard fed by a negedge link monitor.
module tb_noc_request_funnel;

  logic         clk;
  logic         rst_n;
  logic         in_ena;
  logic [127:0] in_v;
  logic         in_rdy;
  logic         out_ena;
  logic [31:0]  out_v;
  logic         out_rdy;
  logic [15:0]  msg_count;
  logic         err_tag;

  int           checks;
  int           errors;
  int           ena_cnt;
  logic [15:0]  exp_count;
  logic [31:0]  exp_q[$];
  logic [31:0]  exp_beat;

  noc_request_funnel dut (
    .CLK          (clk),
    .nRST         (rst_n),
    .in_enq__ENA  (in_ena),
    .in_enq_v     (in_v),
    .in_enq__RDY  (in_rdy),
    .out_enq__ENA (out_ena),
    .out_enq_v    (out_v),
    .out_enq__RDY (out_rdy),
    .msg_count    (msg_count),
    .err_tag      (err_tag)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Link monitor and scoreboard: every transferred beat must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && out_ena) begin
      ena_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got %h, required no beat", out_v);
      end else begin
        exp_beat = exp_q.pop_front();
        if (out_v !== exp_beat) begin
          errors++;
          $display("FAIL beat_order: got %h, required %h", out_v, exp_beat);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one message with the link always ready, checking every cycle.
  task automatic run_msg(input logic [31:0] tag, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input int n, input string name);
    logic [31:0] beats [4];
    beats[0] = {16'(n), tag[15:0]};
    beats[1] = d0;
    beats[2] = d1;
    beats[3] = d2;
    for (int i = 0; i <= n; i++) exp_q.push_back(beats[i]);
    in_ena  = 1'b1;
    in_v    = {d2, d1, d0, tag};
    out_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept_rdy: got %b, required 1", name, in_rdy);
    end
    step();
    in_ena = 1'b0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      checks++;
      if (out_ena !== 1'b1 || out_v !== beats[i] || in_rdy !== (i == n)) begin
        errors++;
        $display("FAIL %s_beat%0d: got ena=%b v=%h rdy=%b, required ena=1 v=%h rdy=%b",
                 name, i, out_ena, out_v, in_rdy, beats[i], (i == n));
      end
      step();
    end
    exp_count = exp_count + 16'd1;
    @(negedge clk);
    checks++;
    if (out_ena !== 1'b0 || msg_count !== exp_count) begin
      errors++;
      $display("FAIL %s_done: got ena=%b count=%0d, required ena=0 count=%0d",
               name, out_ena, msg_count, exp_count);
    end
    step();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    in_ena  = 1'b0;
    in_v    = '0;
    out_rdy = 1'b1;
    exp_count = 16'd0;
    step();
    step();
    checks++;
    if (in_rdy !== 1'b1 || out_ena !== 1'b0 || msg_count !== 16'd0 || err_tag !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b ena=%b count=%0d err=%b, required 1 0 0 0",
               in_rdy, out_ena, msg_count, err_tag);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_say();
    run_msg(32'd1, 32'h11, 32'h22, 32'h0, 2, "say");
  endtask

  task automatic test_say2();
    run_msg(32'd2, 32'hA, 32'hB, 32'hC, 3, "say2");
  endtask

  task automatic test_back_to_back();
    logic [31:0] b [6];
    logic        r [6];
    b = '{32'h00020001, 32'h31, 32'h32, 32'h00020001, 32'h41, 32'h42};
    r = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) exp_q.push_back(b[i]);
    out_rdy = 1'b1;
    in_ena  = 1'b1;
    in_v    = {32'h0, 32'h32, 32'h31, 32'd1};
    step();
    in_v    = {32'h0, 32'h42, 32'h41, 32'd1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_ena !== 1'b1 || out_v !== b[i] || in_rdy !== r[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d: got ena=%b v=%h rdy=%b, required ena=1 v=%h rdy=%b",
                 i, out_ena, out_v, in_rdy, b[i], r[i]);
      end
      step();
      if (i == 2) in_ena = 1'b0;
    end
    exp_count = exp_count + 16'd2;
    @(negedge clk);
    checks++;
    if (out_ena !== 1'b0 || msg_count !== exp_count) begin
      errors++;
      $display("FAIL b2b_done: got ena=%b count=%0d, required ena=0 count=%0d",
               out_ena, msg_count, exp_count);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic        pat [8];
    logic [31:0] ev  [7];
    int          ena_start;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    ev  = '{32'h00030002, 32'h51, 32'h51, 32'h51, 32'h52, 32'h52, 32'h53};
    exp_q.push_back(32'h00030002);
    exp_q.push_back(32'h51);
    exp_q.push_back(32'h52);
    exp_q.push_back(32'h53);
    ena_start = ena_cnt;
    out_rdy = 1'b1;
    in_ena  = 1'b1;
    in_v    = {32'h53, 32'h52, 32'h51, 32'd2};
    step();
    in_ena  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      out_rdy = pat[i];
      @(negedge clk);
      checks++;
      if (out_ena !== pat[i] || out_v !== ev[i]) begin
        errors++;
        $display("FAIL bp_cycle%0d: got ena=%b v=%h, required ena=%b v=%h",
                 i, out_ena, out_v, pat[i], ev[i]);
      end
      step();
    end
    out_rdy = pat[7];
    exp_count = exp_count + 16'd1;
    @(negedge clk);
    checks++;
    if ((ena_cnt - ena_start) != 4 || out_ena !== 1'b0 || msg_count !== exp_count) begin
      errors++;
      $display("FAIL bp_done: got pulses=%0d ena=%b count=%0d, required 4 0 %0d",
               ena_cnt - ena_start, out_ena, msg_count, exp_count);
    end
    step();
  endtask

  task automatic test_bad_tag();
    checks++;
    if (err_tag !== 1'b0) begin
      errors++;
      $display("FAIL err_before: got %b, required 0", err_tag);
    end
    run_msg(32'd7, 32'h71, 32'h72, 32'h73, 3, "tag7");
    checks++;
    if (err_tag !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b, required 1", err_tag);
    end
    run_msg(32'd1, 32'h81, 32'h82, 32'h0, 2, "say_after_bad");
    checks++;
    if (err_tag !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, required 1", err_tag);
    end
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(32'h00030002);
    exp_q.push_back(32'h91);
    out_rdy = 1'b1;
    in_ena  = 1'b1;
    in_v    = {32'h93, 32'h92, 32'h91, 32'd2};
    step();
    in_ena  = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_ena !== 1'b0 || in_rdy !== 1'b1 || msg_count !== 16'd0 || err_tag !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got ena=%b rdy=%b count=%0d err=%b, required 0 1 0 0",
               out_ena, in_rdy, msg_count, err_tag);
    end
    step();
    step();
    rst_n = 1'b1;
    exp_count = 16'd0;
    step();
    run_msg(32'd1, 32'hA1, 32'hA2, 32'h0, 2, "say_post_reset");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL beats_missing: got %0d left, required 0", exp_q.size());
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    ena_cnt = 0;
    test_reset();
    test_say();
    test_say2();
    test_back_to_back();
    test_backpressure();
    test_bad_tag();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_request_funnel.md
Name: noc_request_funnel

Overview:
- Downstream neighbour of the echo-request output stage.
- Accepts one 128-bit EchoRequest_data message per handshake on a PipeIn-style enq port (32-bit tag in bits 31:0, 96-bit data above it).
- Serialises each message onto a 32-bit NOC beat stream: one header beat, then a tag-dependent number of payload beats.
- Feeds the narrow link toward the indication/NOC side, which has the same enq__ENA/enq__RDY handshake.

Parameters:
- MSG_WIDTH, 128, width of in$enq$v (tag 32 + data 96).
- BEAT_WIDTH, 32, width of out$enq$v. MSG_WIDTH must equal 4*BEAT_WIDTH.
- TAG_SAY, 1, tag value of the say request (2 payload beats).
- TAG_SAY2, 2, tag value of the say2 request (3 payload beats).

Ports:
- CLK  input  1  clock; all state changes on its rising edge.
- nRST  input  1  asynchronous, active-low reset.
- in$enq__ENA  input  1  upstream enq strobe; asserted only while in$enq__RDY=1.
- in$enq$v  input  128  message; valid when in$enq__ENA=1.
- in$enq__RDY  output  1  funnel can take a message this cycle.
- out$enq__ENA  output  1  beat transfer this cycle.
- out$enq$v  output  32  beat data.
- out$enq__RDY  input  1  downstream can take a beat.
- msg_count  output  16  count of completed messages (last beat accepted); wraps at 16'hFFFF -> 0.
- err_tag  output  1  sticky flag: a message with an unknown tag was accepted.

Behaviour:
- Reset (nRST=0, asynchronous):
  - State goes to IDLE; beat index = 0; holding register = 0.
  - msg_count = 0; err_tag = 0.
  - Combinational outputs while in reset: in$enq__RDY=1, out$enq__ENA=0.
- States:
  - IDLE: no message held.
  - HDR: header beat pending.
  - PAY: payload beats pending.
- Accept rule: in$enq__RDY = (state==IDLE) | (state==PAY & last & out$enq__RDY).
  - This permits back-to-back messages with no bubble.
- On accept:
  - Latch in$enq$v into the holding register.
  - Set N = 2 if tag==TAG_SAY, 3 if tag==TAG_SAY2, otherwise 3.
  - For any other tag, also set err_tag = 1; the message is still forwarded.
  - Next state is HDR.
- out$enq__ENA = (state!=IDLE) & out$enq__RDY.
  - out$enq$v is a combinational mux of the holding register and beat index; it is stable while out$enq__RDY=0.
- Header beat: {N[15:0], tag[15:0]}. When the transfer happens: HDR -> PAY, index = 0.
- Payload beat i (i = 0..N-1): holding[32*(i+1) +: 32]. Beat 0 of the message (the tag word) is never resent.
  - When a transfer happens with i < N-1: index increments.
  - When a transfer happens with i = N-1 (last):
    - msg_count increments.
    - If in$enq__ENA is also asserted in that cycle, the new message is latched and state -> HDR.
    - Otherwise state -> IDLE.
- Latency:
  - Header is presented the cycle after accept.
  - Minimum message length is 1+N cycles with out$enq__RDY held high; say = 3 cycles, say2 = 4 cycles.
- Backpressure: if out$enq__RDY=0, state, index and data hold. No beat is lost or duplicated.
- Reset during HDR/PAY: the held message is discarded; no partial beat completes. msg_count does not count it.
- msg_count wraps modulo 2^16. err_tag clears only on reset.

Decomposition:
- noc_funnel_pkg holds:
  - typedef funnel_hdr_t {length[15:0], tag[15:0]};
  - localparams TAG_SAY and TAG_SAY2;
  - function payload_beats(tag) returning 2 or 3.
- The module is single-level. The beat mux and the FSM are both small enough that no sub-module is warranted.

Test Plan:
- Reset, then send say tag=1, meth=32'h11, v=32'h22 with RDY=1 -> beats 32'h00020001, 32'h00000011, 32'h00000022 on consecutive cycles; msg_count=1.
- say2 tag=2 {meth=0xA, v=0xB, v2=0xC} -> beats 32'h00030002, 0xA, 0xB, 0xC; in$enq__RDY=0 during header and payload beats 0 and 1.
- Two say messages back-to-back with upstream ENA held -> 6 beats in 6 cycles with no bubble; second accept coincides with first message's last beat; msg_count=2.
- Toggle out$enq__RDY 1,0,0,1,... during a say2 -> each beat value held while RDY=0, no duplicates, exactly 4 ENA pulses.
- Tag=7 message -> header 32'h00030007, 3 payload beats; err_tag rises and stays 1 across later valid messages.
- Assert nRST low mid-payload of say2 -> outputs drop to reset values immediately; a later say message streams correctly; msg_count counts only post-reset messages.
